// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared definitions for the DDS sweep controller.
//   - sweep FSM state encoding
//   - register map addresses
//   - MODE register bit positions
//   - DWELL register reset value
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  localparam logic [2:0] AddrStart = 3'd0;
  localparam logic [2:0] AddrStop  = 3'd1;
  localparam logic [2:0] AddrStep  = 3'd2;
  localparam logic [2:0] AddrDwell = 3'd3;
  localparam logic [2:0] AddrWave  = 3'd4;
  localparam logic [2:0] AddrMode  = 3'd5;

  localparam int unsigned ModeRepeatBit = 0;
  localparam int unsigned DwellDefault  = 1;

endpackage

// File: rtl/dds_ftw_stepper.sv
// dds_ftw_stepper: combinational next-FTW computation for a linear sweep.
// Ports:
//   cur     - current FTW
//   step    - step size (0 jumps straight to stop)
//   stop    - final FTW of the sweep
//   dir_up  - 1: sweep upward, 0: sweep downward
//   next    - next FTW, clamped to stop (never wraps past it)
//   at_stop - cur has reached stop
module dds_ftw_stepper #(
  parameter int unsigned FTW_W = 32
) (
  input  logic [FTW_W-1:0] cur,
  input  logic [FTW_W-1:0] step,
  input  logic [FTW_W-1:0] stop,
  input  logic             dir_up,
  output logic [FTW_W-1:0] next,
  output logic             at_stop
);

  // One extra bit holds the carry (up) or the borrow (down).
  logic [FTW_W:0] sum;
  logic [FTW_W:0] diff;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    next = stop;
    if (step != '0) begin
      if (dir_up) begin
        if (sum < {1'b0, stop}) next = sum[FTW_W-1:0];
      end else begin
        if (!diff[FTW_W] && (diff[FTW_W-1:0] > stop)) next = diff[FTW_W-1:0];
      end
    end
  end

  assign at_stop = (cur == stop);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: drives DDS tuning inputs to produce linear frequency sweeps.
// Ports:
//   Clk, Rst              - DDS clock, synchronous active-high reset
//   cfg_we/addr/wdata     - write-only register port (START/STOP/STEP/DWELL/WAVE/MODE)
//   start, abort          - single-cycle control pulses (abort has priority)
//   ftw_out, wave_sel_out - DDS tuning word and waveform select
//   busy                  - high while loading or running a sweep
//   done                  - one-cycle pulse at sweep completion
//   wrap                  - one-cycle pulse when repeat mode reloads START
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned FTW_W   = 32,  // must not exceed the 32-bit write bus
  parameter int unsigned DWELL_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             start,
  input  logic             abort,
  output logic [FTW_W-1:0] ftw_out,
  output logic [2:0]       wave_sel_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  // Host-visible registers.
  logic [FTW_W-1:0]   reg_start, reg_stop, reg_step;
  logic [DWELL_W-1:0] reg_dwell;
  logic [2:0]         reg_wave;
  logic               reg_repeat;

  // Shadows used by the running sweep.
  logic [FTW_W-1:0]   sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic [2:0]         sh_wave;
  logic               sh_repeat, sh_dir_up;

  state_e             state_q, state_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         wave_q, wave_d;
  logic               wrap_q, wrap_d;
  logic               load_shadow;

  logic [FTW_W-1:0]   step_next;
  logic               at_stop;
  logic [DWELL_W-1:0] dwell_last;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      reg_start  <= '0;
      reg_stop   <= '0;
      reg_step   <= '0;
      reg_dwell  <= DWELL_W'(DwellDefault);
      reg_wave   <= '0;
      reg_repeat <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        AddrStart: reg_start  <= cfg_wdata[FTW_W-1:0];
        AddrStop:  reg_stop   <= cfg_wdata[FTW_W-1:0];
        AddrStep:  reg_step   <= cfg_wdata[FTW_W-1:0];
        AddrDwell: reg_dwell  <= cfg_wdata[DWELL_W-1:0];
        AddrWave:  reg_wave   <= cfg_wdata[2:0];
        AddrMode:  reg_repeat <= cfg_wdata[ModeRepeatBit];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= DWELL_W'(DwellDefault);
      sh_wave   <= '0;
      sh_repeat <= 1'b0;
      sh_dir_up <= 1'b1;
    end else if (load_shadow) begin
      sh_start  <= reg_start;
      sh_stop   <= reg_stop;
      sh_step   <= reg_step;
      sh_dwell  <= reg_dwell;
      sh_wave   <= reg_wave;
      sh_repeat <= reg_repeat;
      sh_dir_up <= (reg_start <= reg_stop);
    end
  end

  dds_ftw_stepper #(
    .FTW_W (FTW_W)
  ) u_stepper (
    .cur     (ftw_q),
    .step    (sh_step),
    .stop    (sh_stop),
    .dir_up  (sh_dir_up),
    .next    (step_next),
    .at_stop (at_stop)
  );

  // DWELL of 0 behaves as 1.
  assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      ftw_q   <= '0;
      cnt_q   <= '0;
      wave_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ftw_d       = ftw_q;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    load_shadow = 1'b0;
    // In LOAD the register value is what the shadow is capturing, so both agree.
    wave_d      = ((state_q == StIdle) || (state_q == StLoad)) ? reg_wave : sh_wave;

    case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        load_shadow = 1'b1;
        ftw_d       = reg_start;
        cnt_d       = '0;
        state_d     = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == dwell_last) begin
          cnt_d = '0;
          if (!at_stop) begin
            ftw_d = step_next;
          end else if (sh_repeat) begin
            ftw_d  = sh_start;
            wrap_d = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d     = StIdle;
      ftw_d       = '0;
      cnt_d       = '0;
      wrap_d      = 1'b0;
      load_shadow = 1'b0;
    end
  end

  assign ftw_out      = ftw_q;
  assign wave_sel_out = wave_q;
  assign busy         = (state_q == StLoad) || (state_q == StRun);
  assign done         = (state_q == StDone);
  assign wrap         = wrap_q;

endmodule
